// File: rtl/alu_div24_seq_if.sv
// rtl/alu_div24_seq_if.sv - Start/Busy/Done handshake bundle between the CPU control unit and the 24-bit divider
//
// Signals:
//   start        control -> divider  request, sampled only when the divider is idle or done
//   a, b         control -> divider  dividend / divisor, registered on an accepted start
//   is_signed    control -> divider  1 = two's-complement operands
//   busy         divider -> control  divide in progress (control unit stalls)
//   done         divider -> control  one-cycle pulse, results valid
//   quotient     divider -> control  result quotient, held until the next accepted start
//   remainder    divider -> control  result remainder, held until the next accepted start
//   div_by_zero  divider -> control  divisor was zero for the current result
//   overflow     divider -> control  signed 0x800000 / 0xFFFFFF case
interface alu_div24_seq_if #(
    parameter int WIDTH = 24
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, a, b, is_signed,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, a, b, is_signed,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/alu_div24_seq.sv
// rtl/alu_div24_seq.sv - sequential 24-bit restoring divider, one quotient bit per clock
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   dif    alu_div24_seq_if.slave handshake/result bundle
//
// Build option: define DIV24_SIGNED_EN to honour is_signed (magnitude capture,
// sign fix-up in FIX, overflow detection). Without it every divide is unsigned,
// FIX still takes one cycle and overflow is tied low.
module alu_div24_seq (
    input  logic            clk,
    input  logic            rst_n,
    alu_div24_seq_if.slave  dif
);
    localparam int WIDTH = 24;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             busy;
    logic             done;

    logic             sgn;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // dvd shifts the dividend out of its top and the quotient bits in at the
    // bottom, so after the last iteration it holds the unsigned quotient.
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   prem;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             trial_ge;
    logic [4:0]       cnt;

    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;

    // The partial remainder is always below the divisor, so its top bit is
    // only ever a guard bit and never feeds the next shift.
    logic             unused_prem_msb;
    assign unused_prem_msb = prem[WIDTH];

`ifdef DIV24_SIGNED_EN
    logic q_neg;
    logic r_neg;
    logic ovf_pend;
    logic ovf_q;

    assign sgn          = dif.is_signed;
    assign q_fix        = q_neg ? -dvd : dvd;
    assign r_fix        = r_neg ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
    assign dif.overflow = ovf_q;
`else
    logic unused_is_signed;

    assign unused_is_signed = dif.is_signed;
    assign sgn              = 1'b0;
    assign q_fix            = dvd;
    assign r_fix            = prem[WIDTH-1:0];
    assign dif.overflow     = 1'b0;
`endif

    assign a_mag = (sgn && dif.a[WIDTH-1]) ? -dif.a : dif.a;
    assign b_mag = (sgn && dif.b[WIDTH-1]) ? -dif.b : dif.b;

    assign shifted  = {prem[WIDTH-1:0], dvd[WIDTH-1]};
    assign trial    = {1'b0, shifted} - {2'b00, dvs};
    assign trial_ge = ~trial[WIDTH+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (dif.start) begin
                    accept    = 1'b1;
                    state_nxt = (dif.b == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (cnt == 5'd0) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (dif.start) begin
                    accept    = 1'b1;
                    state_nxt = (dif.b == '0) ? S_DONE : S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd         <= '0;
            dvs         <= '0;
            prem        <= '0;
            cnt         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef DIV24_SIGNED_EN
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            ovf_pend    <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else if (accept) begin
`ifdef DIV24_SIGNED_EN
            ovf_q <= 1'b0;
`endif
            if (dif.b == '0) begin
                // Divide-by-zero completes on the accept edge.
                quotient_q  <= '1;
                remainder_q <= dif.a;
                dbz_q       <= 1'b1;
            end else begin
                dbz_q    <= 1'b0;
                dvd      <= a_mag;
                dvs      <= b_mag;
                prem     <= '0;
                cnt      <= 5'd23;
`ifdef DIV24_SIGNED_EN
                q_neg    <= sgn & (dif.a[WIDTH-1] ^ dif.b[WIDTH-1]);
                r_neg    <= sgn & dif.a[WIDTH-1];
                ovf_pend <= sgn && (dif.a == 24'h800000) && (dif.b == 24'hFFFFFF);
`endif
            end
        end else begin
            case (state)
                S_RUN: begin
                    prem <= trial_ge ? trial[WIDTH:0] : shifted;
                    dvd  <= {dvd[WIDTH-2:0], trial_ge};
                    cnt  <= cnt - 5'd1;
                end
                S_FIX: begin
                    quotient_q  <= q_fix;
                    remainder_q <= r_fix;
`ifdef DIV24_SIGNED_EN
                    ovf_q       <= ovf_pend;
`endif
                end
                default: ;
            endcase
        end
    end

    assign dif.busy        = busy;
    assign dif.done        = done;
    assign dif.quotient    = quotient_q;
    assign dif.remainder   = remainder_q;
    assign dif.div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_div24_seq.sv
// tb/tb_alu_div24_seq.sv - self-checking bench for alu_div24_seq
module tb_alu_div24_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alu_div24_seq_if #(.WIDTH(24)) dif ();

    alu_div24_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dif   (dif)
    );

    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        logic        s;
        logic [23:0] q;
        logic [23:0] r;
        logic        dbz;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [23:0] q;
        logic [23:0] r;
        logic        dbz;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Drive one accepted start; the expected result goes on the scoreboard.
    task automatic issue(input logic [23:0] a, input logic [23:0] b, input logic s,
                         input logic [23:0] q, input logic [23:0] r,
                         input logic dbz, input logic ovf);
        exp_t e;
        dif.start     = 1'b1;
        dif.a         = a;
        dif.b         = b;
        dif.is_signed = s;
        e.q   = q;
        e.r   = r;
        e.dbz = dbz;
        e.ovf = ovf;
        e.lat = dbz ? 1 : 26;
        sb.push_back(e);
        @(posedge clk);
        #1;
        dif.start     = 1'b0;
        dif.a         = 24'($urandom);
        dif.b         = 24'($urandom);
        dif.is_signed = 1'($urandom);
    endtask

    // Waits for done, counting busy cycles; optionally pulses start mid-run.
    task automatic wait_done(input int pulse_at);
        int   cyc = 0;
        int   busy_n = 0;
        bit   got = 0;
        exp_t e;
        while (!got && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (dif.busy) busy_n++;
            if (dif.done) begin
                got = 1;
            end else if (cyc == pulse_at) begin
                dif.start = 1'b1;
                dif.a     = 24'd50;
                dif.b     = 24'd5;
                @(posedge clk);
                #1;
                dif.start = 1'b0;
            end
        end
        if (!got) begin
            chk("done_timeout", 32'd0, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk("latency", cyc, e.lat);
        chk("busy_cycles", busy_n, e.dbz ? 0 : 25);
        chk("busy_at_done", dif.busy, 0);
        chk("quotient", dif.quotient, e.q);
        chk("remainder", dif.remainder, e.r);
        chk("div_by_zero", dif.div_by_zero, e.dbz);
        chk("overflow", dif.overflow, e.ovf);
    endtask

    initial begin
        vec_t v;
        logic [23:0] ra;
        logic [23:0] rb;
        int extra;

        dif.start     = 1'b0;
        dif.a         = '0;
        dif.b         = '0;
        dif.is_signed = 1'b0;

        vecs.push_back('{24'd100,     24'd7,       1'b0, 24'd14,      24'd2,       1'b0, 1'b0});
        vecs.push_back('{24'h123456,  24'h000000,  1'b0, 24'hFFFFFF,  24'h123456,  1'b1, 1'b0});
        vecs.push_back('{24'hFFFFFF,  24'd1,       1'b0, 24'hFFFFFF,  24'd0,       1'b0, 1'b0});
        vecs.push_back('{24'hFFFFFF,  24'hFFFFFF,  1'b0, 24'd1,       24'd0,       1'b0, 1'b0});
        vecs.push_back('{24'd5,       24'd9,       1'b0, 24'd0,       24'd5,       1'b0, 1'b0});
        vecs.push_back('{24'hABCDEF,  24'h000010,  1'b0, 24'h0ABCDE,  24'h00000F,  1'b0, 1'b0});
        vecs.push_back('{24'd0,       24'd5,       1'b0, 24'd0,       24'd0,       1'b0, 1'b0});
        vecs.push_back('{24'h800000,  24'hFFFFFF,  1'b0, 24'd0,       24'h800000,  1'b0, 1'b0});
`ifdef DIV24_SIGNED_EN
        vecs.push_back('{24'hFFFF9C,  24'd7,       1'b1, 24'hFFFFF2,  24'hFFFFFE,  1'b0, 1'b0});
        vecs.push_back('{24'd100,     24'hFFFFF9,  1'b1, 24'hFFFFF2,  24'd2,       1'b0, 1'b0});
        vecs.push_back('{24'hFFFF9C,  24'hFFFFF9,  1'b1, 24'd14,      24'hFFFFFE,  1'b0, 1'b0});
        vecs.push_back('{24'h800000,  24'hFFFFFF,  1'b1, 24'h800000,  24'd0,       1'b0, 1'b1});
        vecs.push_back('{24'hFFFF9C,  24'd0,       1'b1, 24'hFFFFFF,  24'hFFFF9C,  1'b1, 1'b0});
`else
        vecs.push_back('{24'hFFFF9C,  24'd7,       1'b1, 24'h24923A,  24'd6,       1'b0, 1'b0});
        vecs.push_back('{24'd100,     24'hFFFFF9,  1'b1, 24'd0,       24'd100,     1'b0, 1'b0});
        vecs.push_back('{24'h800000,  24'hFFFFFF,  1'b1, 24'd0,       24'h800000,  1'b0, 1'b0});
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", dif.busy, 0);
        chk("reset_done", dif.done, 0);
        chk("reset_quotient", dif.quotient, 0);
        chk("reset_remainder", dif.remainder, 0);
        chk("reset_dbz", dif.div_by_zero, 0);
        chk("reset_ovf", dif.overflow, 0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(negedge clk);
            issue(v.a, v.b, v.s, v.q, v.r, v.dbz, v.ovf);
            wait_done(0);
        end

        for (int i = 0; i < 6; i++) begin
            ra = 24'($urandom);
            rb = (i < 3) ? 24'($urandom_range(1, 4095)) : 24'($urandom_range(1, 24'hFFFFFF));
            @(negedge clk);
            issue(ra, rb, 1'b0, ra / rb, ra % rb, 1'b0, 1'b0);
            wait_done(0);
        end

        // Start pulse during RUN must be dropped entirely.
        @(negedge clk);
        issue(24'd100, 24'd7, 1'b0, 24'd14, 24'd2, 1'b0, 1'b0);
        wait_done(5);
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (dif.done) extra++;
        end
        chk("ignored_start_no_done", extra, 0);
        chk("held_quotient", dif.quotient, 24'd14);
        chk("held_remainder", dif.remainder, 24'd2);

        // Back-to-back: new start issued in the done cycle.
        @(negedge clk);
        issue(24'd100, 24'd7, 1'b0, 24'd14, 24'd2, 1'b0, 1'b0);
        wait_done(0);
        issue(24'd50, 24'd5, 1'b0, 24'd10, 24'd0, 1'b0, 1'b0);
        wait_done(0);

        // Reset in the middle of a divide, with nonzero results on display.
        @(negedge clk);
        issue(24'h123456, 24'd0, 1'b0, 24'hFFFFFF, 24'h123456, 1'b1, 1'b0);
        wait_done(0);
        @(negedge clk);
        issue(24'd100, 24'd7, 1'b0, 24'd14, 24'd2, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_busy", dif.busy, 0);
        chk("midrun_reset_done", dif.done, 0);
        chk("midrun_reset_quotient", dif.quotient, 0);
        chk("midrun_reset_remainder", dif.remainder, 0);
        chk("midrun_reset_dbz", dif.div_by_zero, 0);
        chk("midrun_reset_ovf", dif.overflow, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(24'd100, 24'd7, 1'b0, 24'd14, 24'd2, 1'b0, 1'b0);
        wait_done(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_div24_seq.md
# alu_div24_seq

Sequential 24-bit integer divider that sits beside the combinational 24-bit ALU in the CPU datapath. It computes the quotient and remainder of A / B using a restoring shift-subtract algorithm, one quotient bit per clock. The CPU control unit drives it through a Start/Busy/Done handshake and stalls while it is Busy. Optional signed-mode support is compiled in by macro.

## Interface
- WIDTH, 24, operand/result width; only 24 is supported and verified.
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  request; sampled only in IDLE or DONE.
- A  in  24  dividend, captured on accepted Start.
- B  in  24  divisor, captured on accepted Start.
- Signed  in  1  1 = two's-complement operands, 0 = unsigned; captured on accepted Start.
- Busy  out  1  high while RUN or FIX.
- Done  out  1  one-cycle pulse; results valid.
- Quotient  out  24  result quotient, held until next accepted Start.
- Remainder  out  24  result remainder, held until next accepted Start.
- DivByZero  out  1  B was 0 for the current result.
- Overflow  out  1  signed 0x800000 / 0xFFFFFF case.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE/DONE + Start, with B != 0:
  - capture |A| and |B|; magnitudes are taken only when Signed = 1, using unsigned 24-bit negation.
  - record the quotient sign (A[23] ^ B[23]) and remainder sign (A[23]).
  - clear the 25-bit partial remainder, load count = 23, go to RUN.
- IDLE/DONE + Start, with B == 0: go to DONE directly.
  - Quotient = 0xFFFFFF, Remainder = A unmodified, DivByZero = 1, Overflow = 0.
- RUN, each cycle:
  - shift {partial remainder, dividend} left one bit.
  - trial-subtract the divisor with a 25-bit subtract.
  - if the result is non-negative, keep it and set quotient bit = 1; else restore and set quotient bit = 0.
  - decrement count; after the count = 0 iteration, go to FIX.
- FIX:
  - negate the quotient if its sign flag is set; negate the remainder if its sign flag is set.
  - update the Quotient/Remainder registers; go to DONE.
- DONE: Done = 1 for this cycle only.
  - Start here is accepted exactly as in IDLE (back-to-back operations).
  - with no Start, go to IDLE.
- Flags are loaded when results are written and cleared on every accepted Start:
  - Overflow = 1 iff Signed = 1, A = 0x800000 and B = 0xFFFFFF. The natural result is Quotient = 0x800000, Remainder = 0.
- Start in RUN or FIX is ignored, with no queuing.
- Remainder sign follows the dividend; the quotient truncates toward zero.

## Timing
- Reset (asynchronous, active-low):
  - state = IDLE.
  - Busy, Done, DivByZero and Overflow = 0; Quotient and Remainder = 0.
- Reset asserted mid-operation aborts immediately.
- After reset release, the first Start is accepted normally.
- Normal divide, Start accepted at edge N:
  - Busy = 1 after edges N through N+24 (24 RUN cycles + 1 FIX cycle).
  - Done = 1 after edge N+25 (single cycle), with Busy = 0.
  - latency: 25 edges.
- Divide-by-zero: Done = 1 after edge N+1; Busy never asserts.
- Quotient/Remainder change only at the FIX edge or the divide-by-zero accept edge; they are stable whenever Done = 1.
- Start must be held only for the one sampling edge; the operands are registered at that edge.

## Configuration
- Macro DIV24_SIGNED_EN.
- Defined: the Signed input is honoured as described, including the sign fix-up in FIX and Overflow detection.
- Undefined: Signed is ignored and all operations are unsigned. The FIX state still occupies one cycle but performs no negation, so latency is unchanged. Overflow is tied to 0.

## Test plan
- Unsigned A = 100, B = 7, Start at edge N -> Done after edge N+25; Quotient = 14, Remainder = 2; Busy high for 25 cycles; flags 0.
- Signed (DIV24_SIGNED_EN) A = 0xFFFF9C (-100), B = 7 -> Quotient = 0xFFFFF2 (-14), Remainder = 0xFFFFFE (-2).
- A = 0x123456, B = 0 -> Done after edge N+1; Quotient = 0xFFFFFF, Remainder = 0x123456, DivByZero = 1, Busy never 1.
- Signed A = 0x800000, B = 0xFFFFFF -> Quotient = 0x800000, Remainder = 0, Overflow = 1.
- Handshake:
  - Start pulses during RUN are ignored and the result equals the first operation's.
  - Start asserted in the Done cycle with A = 50, B = 5 -> second Done 25 edges later, Quotient = 10, Remainder = 0.
- Reset asserted in the 10th RUN cycle -> all outputs 0 and state IDLE immediately; a subsequent 100 / 7 gives 14 r 2 with normal latency.
